eth_tx_arbiter: RTL and testbench



---
 rtl/eth_pkg.sv | 33 +++
 rtl/eth_tx_src_mux.sv | 45 ++++
 rtl/eth_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared encodings and defaults for the Ethernet TX arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam int ETH_IFG_CYCLES    = 12;
    localparam int ETH_MAX_FRAME_LEN = 1526;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        SEND       = 2'd2,
        IFG        = 2'd3
    } tx_state_t;

    typedef enum logic {
        OWN_ARP = 1'b0,
        OWN_UDP = 1'b1
    } owner_t;

    // Only meaningful when at least one request is high.
    function automatic owner_t arb_pick(input logic arp_req, input logic udp_req,
                                        input logic prefer_udp);
        if (arp_req && udp_req) return prefer_udp ? OWN_UDP : OWN_ARP;
        else if (arp_req)       return OWN_ARP;
        else                    return OWN_UDP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_src_mux.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_src_mux
//  Description : Registered 2:1 GMII source mux with force-off gating.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_src_mux
    import eth_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  owner_t     i_sel,
    input  logic       i_force_off,
    input  logic       i_arp_en,
    input  logic [7:0] i_arp_data,
    input  logic       i_udp_en,
    input  logic [7:0] i_udp_data,
    output logic       o_en,
    output logic [7:0] o_data
);

    logic       w_en;
    logic [7:0] w_data;
    logic       r_en;
    logic [7:0] r_data;

    // Data is zeroed whenever the enable is not passed so the PHY bus idles at 0.
    assign w_en   = ~i_force_off & ((i_sel == OWN_UDP) ? i_udp_en : i_arp_en);
    assign w_data = w_en ? ((i_sel == OWN_UDP) ? i_udp_data : i_arp_data) : 8'h00;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en   <= 1'b0;
            r_data <= 8'h00;
        end else begin
            r_en   <= w_en;
            r_data <= w_data;
        end
    end

    assign o_en   = r_en;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_arbiter
//  Description : ARP/UDP GMII transmit arbiter with IFG, start timeout and
//                frame-length truncation. ETH_TX_ARB_RR_EN selects round-robin
//                arbitration instead of fixed ARP priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES    = ETH_IFG_CYCLES,
    parameter int START_TIMEOUT = 64,
    parameter int MAX_FRAME_LEN = ETH_MAX_FRAME_LEN
) (
    input  logic       i_gmii_tx_clk,
    input  logic       i_rst,
    input  logic       i_arp_tx_req,
    output logic       o_arp_tx_valid,
    input  logic       i_arp_gmii_tx_en,
    input  logic [7:0] i_arp_gmii_tx_data,
    input  logic       i_udp_tx_req,
    output logic       o_udp_tx_valid,
    input  logic       i_udp_gmii_tx_en,
    input  logic [7:0] i_udp_gmii_tx_data,
    output logic       o_gmii_tx_en,
    output logic [7:0] o_gmii_tx_data,
    output logic       o_gmii_tx_error,
    output logic       o_frame_err
);

    localparam int c_MAX_ST  = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
    localparam int c_CNT_MAX = (c_MAX_ST > MAX_FRAME_LEN) ? c_MAX_ST : MAX_FRAME_LEN;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_IFG_LAST = c_CNT_W'(IFG_CYCLES - 1);
    // The byte that moves WAIT_START into SEND is already passed, so SEND
    // itself may pass MAX_FRAME_LEN-1 more.
    localparam logic [c_CNT_W-1:0] c_LEN_LAST = c_CNT_W'(MAX_FRAME_LEN - 1);

    tx_state_t            r_state, w_state_nxt;
    owner_t               r_owner, w_owner_nxt;
    owner_t               w_pick;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_trunc, w_trunc_nxt;
    logic                 r_frame_err, w_err_nxt;
    logic                 w_pass;
    logic                 w_own_en;
    logic                 w_own_req;
    logic                 w_any_req;
    logic                 w_grant;
    logic                 w_rr_prefer_udp;

`ifdef ETH_TX_ARB_RR_EN
    logic r_rr_prefer_udp;

    always_ff @(posedge i_gmii_tx_clk) begin
        if (i_rst) begin
            r_rr_prefer_udp <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_rr_prefer_udp <= (w_pick == OWN_ARP);
        end
    end

    assign w_rr_prefer_udp = r_rr_prefer_udp;
`else
    assign w_rr_prefer_udp = 1'b0;
`endif

    assign w_any_req = i_arp_tx_req | i_udp_tx_req;
    assign w_pick    = arb_pick(i_arp_tx_req, i_udp_tx_req, w_rr_prefer_udp);
    assign w_own_en  = (r_owner == OWN_UDP) ? i_udp_gmii_tx_en : i_arp_gmii_tx_en;
    assign w_own_req = (r_owner == OWN_UDP) ? i_udp_tx_req     : i_arp_tx_req;

    // In SEND the grant follows the owner's tx_en so it falls with the frame end.
    assign w_grant = (r_state == WAIT_START) | ((r_state == SEND) & w_own_en);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_trunc_nxt = r_trunc;
        w_err_nxt   = 1'b0;
        w_pass      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = WAIT_START;
                    w_cnt_nxt   = '0;
                    w_trunc_nxt = 1'b0;
                end
            end
            WAIT_START: begin
                if (w_own_en) begin
                    w_pass      = 1'b1;
                    w_state_nxt = SEND;
                    w_cnt_nxt   = '0;
                end else if (!w_own_req) begin
                    w_state_nxt = IFG;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IFG;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            SEND: begin
                if (!w_own_en) begin
                    w_state_nxt = IFG;
                    w_cnt_nxt   = '0;
                end else if (!r_trunc) begin
                    if (r_cnt == c_LEN_LAST) begin
                        w_trunc_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_pass    = 1'b1;
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
            end
            IFG: begin
                if (r_cnt == c_IFG_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_gmii_tx_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_ARP;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_trunc     <= w_trunc_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    eth_tx_src_mux u_src_mux (
        .i_clk       (i_gmii_tx_clk),
        .i_rst       (i_rst),
        .i_sel       (r_owner),
        .i_force_off (~w_pass),
        .i_arp_en    (i_arp_gmii_tx_en),
        .i_arp_data  (i_arp_gmii_tx_data),
        .i_udp_en    (i_udp_gmii_tx_en),
        .i_udp_data  (i_udp_gmii_tx_data),
        .o_en        (o_gmii_tx_en),
        .o_data      (o_gmii_tx_data)
    );

    assign o_arp_tx_valid  = w_grant & (r_owner == OWN_ARP);
    assign o_udp_tx_valid  = w_grant & (r_owner == OWN_UDP);
    assign o_gmii_tx_error = 1'b0;
    assign o_frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_tx_arbiter
//  Description : Randomized scoreboard bench for eth_tx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arbiter;

    localparam int IFG_CYCLES    = 12;
    localparam int START_TIMEOUT = 64;
    localparam int MAX_FRAME_LEN = 1526;

    logic       clk = 1'b0;
    logic       rst;
    logic       arp_req, arp_en, udp_req, udp_en;
    logic [7:0] arp_data, udp_data;
    logic       arp_valid, udp_valid, tx_en, tx_error, frame_err;
    logic [7:0] tx_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_err = 0;
    int err_cycles = 0;
    int a5_seen = 0;
    int model_last = 1;
    int idle_run = 1000;
    bit in_frame = 1'b0;
    bit noise_on;

    int         exp_lens[$];
    int         exp_start[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] cap[$];
    int         grant_seq[$];

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_tx_arbiter dut (
        .i_gmii_tx_clk      (clk),
        .i_rst              (rst),
        .i_arp_tx_req       (arp_req),
        .o_arp_tx_valid     (arp_valid),
        .i_arp_gmii_tx_en   (arp_en),
        .i_arp_gmii_tx_data (arp_data),
        .i_udp_tx_req       (udp_req),
        .o_udp_tx_valid     (udp_valid),
        .i_udp_gmii_tx_en   (udp_en),
        .i_udp_gmii_tx_data (udp_data),
        .o_gmii_tx_en       (tx_en),
        .o_gmii_tx_data     (tx_data),
        .o_gmii_tx_error    (tx_error),
        .o_frame_err        (frame_err)
    );

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic grant_of(input int src);
        return (src == 0) ? arp_valid : udp_valid;
    endfunction

    // Higher-level arbitration rule: fixed ARP priority, or "whoever did not win last".
    function automatic int expected_winner();
`ifdef ETH_TX_ARB_RR_EN
        return (model_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic set_req(input int src, input logic v);
        if (src == 0) arp_req = v; else udp_req = v;
    endtask

    task automatic set_en(input int src, input logic v, input logic [7:0] d);
        if (src == 0) begin arp_en = v; arp_data = d; end
        else begin udp_en = v; udp_data = d; end
    endtask

    task automatic idle_wait();
        repeat (IFG_CYCLES + 4) @(posedge clk);
        #1;
    endtask

    // Source model: request, wait for grant, idle dly cycles, send len bytes.
    task automatic send_frame(input int src, input int dly, input int len, input int exp_wait);
        int waited;
        int nout;
        bit held;
        logic [7:0] d;
        set_req(src, 1'b1);
        waited = 0;
        while (!grant_of(src) && waited < 4000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!grant_of(src)) begin
            chk(1'b0, "grant_wait_expired", waited, exp_wait);
            set_req(src, 1'b0);
            return;
        end
        if (exp_wait >= 0) chk(waited == exp_wait, "grant_latency", waited, exp_wait);
        grant_seq.push_back(src);
        model_last = src;
        held = 1'b1;
        repeat (dly) begin
            @(posedge clk); #1;
            held &= grant_of(src);
        end
        nout = (len > MAX_FRAME_LEN) ? MAX_FRAME_LEN : len;
        if (len > MAX_FRAME_LEN) exp_err++;
        exp_lens.push_back(nout);
        exp_start.push_back(cyc + 1);
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            if (d == 8'hA5) d = 8'h5A;
            set_en(src, 1'b1, d);
            if (i < MAX_FRAME_LEN) exp_bytes.push_back(d);
            #1;
            held &= grant_of(src);
            @(posedge clk); #1;
        end
        set_en(src, 1'b0, 8'h00);
        set_req(src, 1'b0);
        #1;
        chk(held, "grant_held", held, 1);
        chk(!grant_of(src), "grant_drop_with_en", grant_of(src), 0);
    endtask

    task automatic no_start(input int src);
        int n;
        int e0;
        e0 = err_cycles;
        set_req(src, 1'b1);
        @(posedge clk); #1;
        chk(grant_of(src), "timeout_grant_rise", grant_of(src), 1);
        grant_seq.push_back(src);
        model_last = src;
        n = 0;
        while (grant_of(src) && n < 4 * START_TIMEOUT) begin
            n++;
            @(posedge clk); #1;
        end
        chk(n == START_TIMEOUT, "timeout_grant_cycles", n, START_TIMEOUT);
        exp_err++;
        set_req(src, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk(err_cycles == e0 + 1, "timeout_err_pulse", err_cycles - e0, 1);
    endtask

    task automatic drop_req(input int src);
        set_req(src, 1'b1);
        @(posedge clk); #1;
        chk(grant_of(src), "release_grant_rise", grant_of(src), 1);
        grant_seq.push_back(src);
        model_last = src;
        @(posedge clk); #1;
        set_req(src, 1'b0);
        @(posedge clk); #1;
        chk(!grant_of(src), "release_grant_drop", grant_of(src), 0);
    endtask

    task automatic dual_round(input int la, input int lu);
        int win;
        int da, du;
        win = expected_winner();
        da = $urandom_range(0, 3);
        du = $urandom_range(0, 3);
        grant_seq.delete();
        fork
            send_frame(0, da, la, (win == 0) ? 1 : -1);
            send_frame(1, du, lu, (win == 1) ? 1 : -1);
        join
        chk(grant_seq.size() == 2 && grant_seq[0] == win && grant_seq[1] == 1 - win,
            "dual_order", (grant_seq.size() > 0) ? grant_seq[0] : -1, win);
    endtask

    // Monitor: collects PHY frames and pops expectations when a frame ends.
    always @(negedge clk) begin
        int l;
        int mism;
        logic [7:0] e;
        if (rst) begin
            in_frame = 1'b0;
            cap.delete();
            idle_run = 1000;
        end else begin
            if (tx_data == 8'hA5) a5_seen++;
            if (frame_err) err_cycles++;
            if (tx_en) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    chk(idle_run >= IFG_CYCLES, "ifg_gap", idle_run, IFG_CYCLES);
                    if (exp_start.size() == 0) chk(1'b0, "unexpected_frame_start", cyc, -1);
                    else begin
                        l = exp_start.pop_front();
                        chk(cyc == l, "frame_start_cycle", cyc, l);
                    end
                end
                cap.push_back(tx_data);
            end else if (in_frame) begin
                in_frame = 1'b0;
                idle_run = 1;
                if (exp_lens.size() == 0) chk(1'b0, "unexpected_frame", cap.size(), 0);
                else begin
                    l = exp_lens.pop_front();
                    chk(cap.size() == l, "frame_len", cap.size(), l);
                    mism = 0;
                    for (int i = 0; i < l; i++) begin
                        e = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
                        if (i >= cap.size() || cap[i] != e) mism++;
                    end
                    chk(mism == 0, "frame_data_mismatches", mism, 0);
                end
                cap.delete();
            end else begin
                idle_run++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mode;
        rst = 1'b1;
        arp_req = 0; arp_en = 0; arp_data = 0;
        udp_req = 0; udp_en = 0; udp_data = 0;
        repeat (4) @(posedge clk);
        #1;
        chk({tx_en, tx_data, tx_error, frame_err, arp_valid, udp_valid} == 13'd0,
            "reset_outputs", {tx_en, tx_data, tx_error, frame_err, arp_valid, udp_valid}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_frame(0, 3, 72, 1);
        idle_wait();

        dual_round(30, 40); idle_wait();
        dual_round(25, 20); idle_wait();
        dual_round(10, 12); idle_wait();

        no_start(1);
        idle_wait();

        send_frame(1, 0, 1600, 1);
        idle_wait();

        drop_req(0);
        idle_wait();

        noise_on = 1'b1;
        fork
            begin
                send_frame(0, 2, 60, 1);
                noise_on = 1'b0;
            end
            begin
                while (noise_on) begin
                    udp_en = 1'($urandom);
                    udp_data = 8'hA5;
                    @(posedge clk); #1;
                end
                udp_en = 1'b0;
                udp_data = 8'h00;
            end
        join
        idle_wait();

        // Reset in the middle of an ARP frame.
        arp_req = 1'b1;
        @(posedge clk); #1;
        chk(arp_valid, "pre_reset_grant", arp_valid, 1);
        exp_start.push_back(cyc + 1);
        for (int i = 0; i < 20; i++) begin
            arp_en = 1'b1;
            arp_data = 8'(i + 1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk({tx_en, tx_data, frame_err, arp_valid, udp_valid} == 12'd0,
            "mid_frame_reset_outputs", {tx_en, tx_data, frame_err, arp_valid, udp_valid}, 0);
        rst = 1'b0;
        arp_req = 1'b0; arp_en = 1'b0; arp_data = 8'h00;
        model_last = 1;
        @(posedge clk); #1;
        send_frame(0, 1, 33, 1);
        idle_wait();

        for (int it = 0; it < 16; it++) begin
            mode = $urandom_range(0, 5);
            if (mode <= 1)      send_frame(mode, $urandom_range(0, 5), $urandom_range(1, 120), 1);
            else if (mode <= 3) dual_round($urandom_range(1, 80), $urandom_range(1, 80));
            else if (mode == 4) no_start($urandom_range(0, 1));
            else                send_frame($urandom_range(0, 1), 0, $urandom_range(1, 3), 1);
            idle_wait();
        end

        idle_wait();
        chk(exp_lens.size() == 0, "frames_missing", exp_lens.size(), 0);
        chk(exp_start.size() == 0, "frame_starts_missing", exp_start.size(), 0);
        chk(err_cycles == exp_err, "frame_err_pulses", err_cycles, exp_err);
        chk(a5_seen == 0, "non_owner_data_leak", a5_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
